norm_writeback: RTL and testbench

Downstream stage of the normalization unit: captures each normalized output vector when the unit's per-column write strobe fires, saturates every column from bw_psum-bit signed to bw-bit signed, packs the row into one word, buffers it in a small FIFO, and writes it to the output SRAM over a shared, grant-arbitrated port with an auto-incrementing address. Completion of a programmed number of rows raises `done`; lost rows raise a sticky error.

---
 rtl/norm_writeback_pkg.sv | 29 ++
 rtl/norm_writeback_wb_fifo.sv | 62 ++++++
 rtl/norm_writeback.sv | 135 +++++++++++++
 tb/tb_norm_writeback.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_writeback_pkg.sv
// Shared widths, saturation limits and FSM states for the
// normalization write-back stage.
package norm_writeback_pkg;

    localparam int COL        = 8;
    localparam int BW         = 8;
    localparam int BW_PSUM    = 2 * BW + 4;
    localparam int ADDR_W     = 4;
    localparam int NUM_ROWS   = 8;
    localparam int FIFO_DEPTH = 4;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(BW);
    localparam int SAT_MIN = sat_min(BW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/norm_writeback_wb_fifo.sv
// Small synchronous row buffer between capture and the SRAM port.
// Flush is synchronous; a push into a full buffer is accepted only with a pop.
module wb_fifo
    import norm_writeback_pkg::*;
#(
    parameter int width = BW * COL,
    parameter int depth = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int ptr_w = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [ptr_w:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (ptr_w + 1)'(depth);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            count <= count + (ptr_w + 1)'(do_push)
                           - (ptr_w + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/norm_writeback.sv
// Normalization write-back: saturate and pack each captured vector,
// buffer it, and stream rows to the shared output SRAM port.
module norm_writeback
    import norm_writeback_pkg::*;
#(
    parameter int col        = COL,
    parameter int bw         = BW,
    parameter int bw_psum    = 2 * bw + 4,
    parameter int addr_w     = ADDR_W,
    parameter int num_rows   = NUM_ROWS,
    parameter int fifo_depth = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_addr,
    input  logic [col-1:0]         norm_wr,
    input  logic [bw_psum*col-1:0] sfp_out,
    input  logic                   mem_grant,
    output logic                   mem_cen,
    output logic                   mem_wen,
    output logic [addr_w-1:0]      mem_a,
    output logic [bw*col-1:0]      mem_d,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int row_w = bw * col;
    localparam int cnt_w = $clog2(num_rows + 1);

    localparam logic signed [bw_psum-1:0] hi = bw_psum'(sat_max(bw));
    localparam logic signed [bw_psum-1:0] lo = bw_psum'(sat_min(bw));
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_rows);

    state_t            state;
    state_t            state_nx;
    logic [addr_w-1:0] addr;
    logic [cnt_w-1:0]  rows;
    logic [row_w-1:0]  row;
    logic [row_w-1:0]  head;
    logic              full;
    logic              empty;
    logic              in_run;
    logic              last;
    logic              push;
    logic              stray;
    logic              issue;
    logic              drop;

    for (genvar i = 0; i < col; i++) begin : g_sat
        logic signed [bw_psum-1:0] v;
        assign v = sfp_out[bw_psum*i +: bw_psum];
        assign row[bw*i +: bw] = (v > hi) ? hi[bw-1:0] :
                                 (v < lo) ? lo[bw-1:0] :
                                 v[bw-1:0];
    end

    assign in_run = state == RUN;
    assign last   = rows == last_cnt;
    assign push   = in_run && (&norm_wr) && !start;
    // Anything on the strobe that is not a clean capture is a protocol error.
    assign stray  = !start && (|norm_wr) && !push;
    assign issue  = in_run && !start && !empty && mem_grant && !last;
    assign drop   = push && full && !issue;

    wb_fifo #(
        .width(row_w),
        .depth(fifo_depth)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(start),
        .push (push),
        .pop  (issue),
        .din  (row),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = RUN;
        end else if (in_run && last) begin
            state_nx = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            rows    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mem_cen <= 1'b1;
            mem_wen <= 1'b1;
            mem_a   <= '0;
            mem_d   <= '0;
        end else begin
            busy    <= state_nx == RUN;
            done    <= state_nx == DONE;
            mem_cen <= !issue;
            mem_wen <= !issue;
            if (start) begin
                addr <= base_addr;
                rows <= '0;
                err  <= 1'b0;
            end else begin
                if (issue) begin
                    addr <= addr + addr_w'(1);
                    rows <= rows + cnt_w'(1);
                end
                if (stray || drop) begin
                    err <= 1'b1;
                end
            end
            if (issue) begin
                mem_a <= addr;
                mem_d <= head;
            end
        end
    end

endmodule

// File: tb/tb_norm_writeback.sv
// Self-checking bench for norm_writeback: randomized rows against a
// queue-based scoreboard of expected SRAM writes.
module tb_norm_writeback;

    localparam int C = 8;
    localparam int W = 8;
    localparam int P = 2 * W + 4;
    localparam int A = 4;
    localparam int R = 8;

    typedef int vec_t [C];

    typedef struct {
        int           cyc;
        logic [A-1:0] a;
        logic [W*C-1:0] d;
        logic         wen;
    } wr_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [A-1:0]   base_addr;
    logic [C-1:0]   norm_wr;
    logic [P*C-1:0] sfp_out;
    logic           mem_grant;
    logic           mem_cen;
    logic           mem_wen;
    logic [A-1:0]   mem_a;
    logic [W*C-1:0] mem_d;
    logic           busy;
    logic           done;
    logic           err;

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    wr_t got[$];
    wr_t expq[$];

    norm_writeback #(
        .col(C), .bw(W), .bw_psum(P), .addr_w(A),
        .num_rows(R), .fifo_depth(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .norm_wr  (norm_wr),
        .sfp_out  (sfp_out),
        .mem_grant(mem_grant),
        .mem_cen  (mem_cen),
        .mem_wen  (mem_wen),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_cen === 1'b0)
            got.push_back(wr_t'{cyc, mem_a, mem_d, mem_wen});
    end

    function automatic logic [W-1:0] sat(input int v);
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic logic [W*C-1:0] to_row(input vec_t v);
        logic [W*C-1:0] r;
        for (int i = 0; i < C; i++) r[W*i +: W] = sat(v[i]);
        return r;
    endfunction

    function automatic logic [P*C-1:0] to_sfp(input vec_t v);
        logic [P*C-1:0] r;
        for (int i = 0; i < C; i++) r[P*i +: P] = v[i][P-1:0];
        return r;
    endfunction

    task automatic rand_vec(output vec_t v);
        for (int i = 0; i < C; i++) begin
            if ($urandom_range(0, 3) == 0)
                v[i] = int'($urandom_range(0, 1048575)) - 524288;
            else
                v[i] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [C-1:0] wr, input vec_t v);
        norm_wr = wr;
        sfp_out = to_sfp(v);
    endtask

    task automatic pulse_start(input int b);
        base_addr = A'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        norm_wr = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_cen, mem_wen} !== 2'b11) begin
            errors++;
            $display("FAIL reset_cen_wen: got %b want 11", {mem_cen, mem_wen});
        end
        checks++;
        if (mem_a !== '0 || mem_d !== '0) begin
            errors++;
            $display("FAIL reset_a_d: got a=%h d=%h want 0 0", mem_a, mem_d);
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, err});
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || mem_cen !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b cen=%b want 0 1",
                     busy, mem_cen);
        end
    endtask

    task automatic test_basic();
        vec_t v;
        int dcyc;
        for (int i = 0; i < C; i++) v[i] = (i % 2 == 0) ? 5 : -5;
        got.delete();
        expq.delete();
        mem_grant = 1'b1;
        pulse_start(3);
        checks++;
        if ({busy, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL basic_start: got %b want 100", {busy, done, err});
        end
        for (int j = 0; j < R; j++) begin
            beat(8'hFF, v);
            expq.push_back(wr_t'{cyc + 2, A'(3 + j), to_row(v), 1'b0});
            tick();
        end
        beat(8'h00, v);
        dcyc = -1;
        for (int t = 0; t < 20 && dcyc < 0; t++) begin
            if (done === 1'b1) dcyc = cyc;
            else tick();
        end
        checks++;
        if (got.size() != expq.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d want %0d", got.size(), expq.size());
        end
        for (int j = 0; j < expq.size() && j < got.size(); j++) begin
            checks++;
            if (got[j].a !== expq[j].a || got[j].d !== expq[j].d ||
                got[j].cyc != expq[j].cyc || got[j].wen !== 1'b0) begin
                errors++;
                $display("FAIL basic_wr%0d: got a=%0d d=%h c=%0d w=%b want a=%0d d=%h c=%0d",
                         j, got[j].a, got[j].d, got[j].cyc, got[j].wen,
                         expq[j].a, expq[j].d, expq[j].cyc);
            end
        end
        if (got.size() > 0) begin
            checks++;
            if (dcyc != got[got.size()-1].cyc + 1) begin
                errors++;
                $display("FAIL basic_done_cycle: got %0d want %0d",
                         dcyc, got[got.size()-1].cyc + 1);
            end
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_end_flags: got busy=%b err=%b want 0 0", busy, err);
        end
    endtask

    task automatic test_saturation();
        vec_t v;
        vec_t r;
        logic [W*C-1:0] want;
        v = '{200, -300, 127, -128, 524287, -524288, 128, -129};
        want = {8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
        rand_vec(r);
        got.delete();
        mem_grant = 1'b1;
        pulse_start(0);
        beat(8'hFF, v);
        tick();
        beat(8'hFF, r);
        tick();
        beat(8'h00, r);
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL sat_count: got %0d want 2", got.size());
        end else begin
            checks++;
            if (got[0].d !== want) begin
                errors++;
                $display("FAIL sat_fixed: got %h want %h", got[0].d, want);
            end
            checks++;
            if (got[1].d !== to_row(r) || got[1].a !== A'(1)) begin
                errors++;
                $display("FAIL sat_rand: got a=%0d d=%h want a=1 d=%h",
                         got[1].a, got[1].d, to_row(r));
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v;
        got.delete();
        expq.delete();
        mem_grant = 1'b0;
        pulse_start(0);
        for (int j = 0; j < 6; j++) begin
            rand_vec(v);
            beat(8'hFF, v);
            if (j < 4) expq.push_back(wr_t'{0, A'(j), to_row(v), 1'b0});
            tick();
        end
        beat(8'h00, v);
        checks++;
        if (err !== 1'b1 || got.size() != 0) begin
            errors++;
            $display("FAIL bp_drop: got err=%b writes=%0d want 1 0", err, got.size());
        end
        mem_grant = 1'b1;
        for (int t = 0; t < 8; t++) tick();
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d want 4", got.size());
        end
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            checks++;
            if (got[j].a !== expq[j].a || got[j].d !== expq[j].d) begin
                errors++;
                $display("FAIL bp_wr%0d: got a=%0d d=%h want a=%0d d=%h",
                         j, got[j].a, got[j].d, expq[j].a, expq[j].d);
            end
        end
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_sticky: got err=%b busy=%b want 1 1", err, busy);
        end
    endtask

    task automatic test_wrap_full();
        vec_t v;
        int t;
        got.delete();
        expq.delete();
        mem_grant = 1'b0;
        pulse_start(14);
        for (int j = 0; j < R; j++) begin
            if (j == 4) mem_grant = 1'b1;
            rand_vec(v);
            beat(8'hFF, v);
            expq.push_back(wr_t'{0, A'(14 + j), to_row(v), 1'b0});
            tick();
        end
        beat(8'h00, v);
        for (t = 0; t < 30 && done !== 1'b1; t++) tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got done=%b err=%b want 1 0", done, err);
        end
        checks++;
        if (got.size() != R) begin
            errors++;
            $display("FAIL wrap_count: got %0d want %0d", got.size(), R);
        end
        for (int j = 0; j < R && j < got.size(); j++) begin
            checks++;
            if (got[j].a !== expq[j].a || got[j].d !== expq[j].d) begin
                errors++;
                $display("FAIL wrap_wr%0d: got a=%0d d=%h want a=%0d d=%h",
                         j, got[j].a, got[j].d, expq[j].a, expq[j].d);
            end
        end
        got.delete();
        beat(8'hFF, v);
        tick();
        beat(8'h00, v);
        for (t = 0; t < 3; t++) tick();
        checks++;
        if (err !== 1'b1 || got.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_stray: got err=%b writes=%0d done=%b want 1 0 1",
                     err, got.size(), done);
        end
    endtask

    task automatic test_protocol();
        vec_t v;
        rand_vec(v);
        do_reset();
        got.delete();
        mem_grant = 1'b1;
        beat(8'hFF, v);
        tick();
        beat(8'h00, v);
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (err !== 1'b1 || got.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_stray: got err=%b writes=%0d busy=%b want 1 0 0",
                     err, got.size(), busy);
        end
        beat(8'hFF, v);
        pulse_start(2);
        beat(8'h00, v);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beat: got err=%b busy=%b want 0 1", err, busy);
        end
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL start_beat_write: got %0d writes want 0", got.size());
        end
        beat(8'h0F, v);
        tick();
        beat(8'h00, v);
        for (int t = 0; t < 4; t++) tick();
        checks++;
        if (err !== 1'b1 || got.size() != 0) begin
            errors++;
            $display("FAIL mixed_mask: got err=%b writes=%0d want 1 0", err, got.size());
        end
    endtask

    task automatic test_random();
        vec_t v;
        int b;
        int n;
        int t;
        int burst;
        got.delete();
        expq.delete();
        b = int'($urandom_range(0, 15));
        mem_grant = 1'b1;
        pulse_start(b);
        n = 0;
        while (n < R) begin
            burst = int'($urandom_range(1, 3));
            if (burst > R - n) burst = R - n;
            for (int k = 0; k < burst; k++) begin
                rand_vec(v);
                beat(8'hFF, v);
                expq.push_back(wr_t'{0, A'(b + n), to_row(v), 1'b0});
                n++;
                mem_grant = 1'($urandom_range(0, 1));
                tick();
            end
            beat(8'h00, v);
            for (t = 0; t < 60 && got.size() < expq.size(); t++) begin
                mem_grant = 1'($urandom_range(0, 1));
                tick();
            end
        end
        mem_grant = 1'b1;
        for (t = 0; t < 10 && done !== 1'b1; t++) tick();
        checks++;
        if (got.size() != R || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rand_job: got writes=%0d done=%b err=%b want %0d 1 0",
                     got.size(), done, err, R);
        end
        for (int j = 0; j < R && j < got.size(); j++) begin
            checks++;
            if (got[j].a !== expq[j].a || got[j].d !== expq[j].d ||
                got[j].wen !== 1'b0) begin
                errors++;
                $display("FAIL rand_wr%0d: got a=%0d d=%h want a=%0d d=%h",
                         j, got[j].a, got[j].d, expq[j].a, expq[j].d);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t v;
        int t;
        got.delete();
        expq.delete();
        mem_grant = 1'b1;
        pulse_start(5);
        for (int j = 0; j < 5; j++) begin
            rand_vec(v);
            beat(8'hFF, v);
            tick();
        end
        beat(8'h00, v);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_cen, mem_wen, busy, done, err} !== 5'b11000 ||
            mem_a !== '0 || mem_d !== '0) begin
            errors++;
            $display("FAIL mid_reset_out: got cen=%b wen=%b a=%0d d=%h b=%b d=%b e=%b",
                     mem_cen, mem_wen, mem_a, mem_d, busy, done, err);
        end
        tick();
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL mid_reset_writes: got %0d want 3", got.size());
        end
        reset = 1'b0;
        got.delete();
        pulse_start(0);
        for (t = 0; t < 5; t++) tick();
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_fifo: got %0d writes want 0", got.size());
        end
        for (int j = 0; j < R; j++) begin
            rand_vec(v);
            beat(8'hFF, v);
            expq.push_back(wr_t'{cyc + 2, A'(j), to_row(v), 1'b0});
            tick();
        end
        beat(8'h00, v);
        for (t = 0; t < 20 && done !== 1'b1; t++) tick();
        checks++;
        if (got.size() != R || done !== 1'b1) begin
            errors++;
            $display("FAIL rerun_job: got writes=%0d done=%b want %0d 1",
                     got.size(), done, R);
        end
        for (int j = 0; j < R && j < got.size(); j++) begin
            checks++;
            if (got[j].a !== expq[j].a || got[j].d !== expq[j].d ||
                got[j].cyc != expq[j].cyc) begin
                errors++;
                $display("FAIL rerun_wr%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                         j, got[j].a, got[j].d, got[j].cyc,
                         expq[j].a, expq[j].d, expq[j].cyc);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        norm_wr = '0;
        sfp_out = '0;
        mem_grant = 1'b0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_wrap_full();
        test_protocol();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
